icache_fetch_responder: RTL and testbench
=========================================

Name: icache_fetch_responder

Overview:
- Instruction-side memory responder for the pipelined LC-3b datapath.
- Accepts fetch requests (PC address plus read strobe) from the fetch stage and returns a 16-bit instruction with a one-cycle response pulse.
- Direct-mapped, read-only cache holding 128-bit lines.
- Misses are filled from physical memory over a 128-bit line-read handshake.

Parameters:
NUM_SETS, 8, number of direct-mapped sets; power of 2, 2..64; index width = log2(NUM_SETS)
LINE_BITS, 128, line size in bits (8 words); fixed, not to be overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
mem_address  input  16  fetch byte address (CPU pc); bit 0 ignored
mem_read  input  1  fetch request; held with a stable address until mem_resp
mem_rdata  output  16  instruction word; valid only while mem_resp=1, else 0x0000
mem_resp  output  1  single-cycle response pulse
inv_all  input  1  invalidate all lines (pulse)
pmem_address  output  16  line-aligned fill address (bits [3:0]=0)
pmem_read  output  1  line fill request; held until pmem_resp
pmem_rdata  input  128  fill data; word i = bits [16i+15:16i]
pmem_resp  input  1  fill complete; pmem_rdata valid this cycle

Behaviour:
- Address split: offset=[3:0], word select=[3:1], index=[3+IW:4], tag=[15:4+IW]; IW=log2(NUM_SETS). Default: index [6:4], tag [15:7] (9 bits).
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all valid bits=0; req_addr=0.
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_address=0.
  - Tag/data arrays are not cleared.
- FSM states: IDLE, CHECK, FILL.
- IDLE:
  - mem_read=1 at an edge: latch mem_address into req_addr; go to CHECK.
  - Otherwise stay in IDLE.
- CHECK: hit = valid[idx] && tag[idx]==req tag.
  - hit and mem_read=1: mem_resp=1, mem_rdata=data[idx] word[req word sel]; next state IDLE.
  - hit and mem_read=0 (request abandoned, e.g. pipeline flush): no resp; next state IDLE.
  - miss and mem_read=1: next state FILL.
  - miss and mem_read=0: next state IDLE.
- FILL:
  - pmem_read=1; pmem_address={req tag, req index, 4'b0000}.
  - On pmem_resp=1: write data[idx]=pmem_rdata, tag[idx]=req tag, valid[idx]=1; next state CHECK, which then hits.
  - The fill always completes once started, even if mem_read drops meanwhile.
  - pmem_read and pmem_address stay stable until pmem_resp.
- Latency:
  - Hit: request sampled at edge N, mem_resp high in cycle N+1.
  - Miss: mem_resp high in the cycle after the pmem_resp edge.
  - Throughput: at most one fetch per 2 cycles.
- Back-to-back: mem_read still high in the IDLE cycle after mem_resp is a new request, sampling the current mem_address.
- mem_address changes while a request is pending are ignored; req_addr is authoritative.
- pmem_resp outside FILL is ignored.
- inv_all:
  - Clears all valid bits at the next edge, in any state.
  - If it coincides with the fill write, inv_all wins: the line is written with valid=0, CHECK misses, and a refill follows.
  - If it coincides with CHECK, the hit is evaluated on pre-invalidation valid bits for that cycle.
- Reset mid-FILL: pmem_read drops immediately (combinational from async-reset state); the in-flight pmem_resp is ignored after release.
- mem_resp is never asserted for two consecutive cycles.

Decomposition:
- Add to lc3b_types:
  - lc3b_c_line (logic [127:0])
  - lc3b_c_tag (logic [8:0])
  - lc3b_c_index (logic [2:0])
  - lc3b_c_wordsel (logic [2:0])
- Sub-module icache_array holds the per-set valid, tag and data storage:
  - combinational read by index;
  - synchronous write enable;
  - global clear input for inv_all/reset, with clear priority over write.
- FSM, address split and word mux live in icache_fetch_responder.

Test Plan:
1. Cold read 0x0006 after reset, fill line word i=0x1001*(i+1) -> pmem_read=1 with pmem_address=0x0000 until pmem_resp; mem_resp one cycle later with mem_rdata=0x4004.
2. Following read 0x000A -> mem_resp the cycle after request, mem_rdata=0x6006, pmem_read never asserted.
3. Read 0x0080 (index 0, tag 1) -> miss, pmem_address=0x0080, evicts line 0; read 0x0000 -> miss again, pmem_address=0x0000.
4. inv_all pulse in IDLE, then read 0x000A -> miss and refill; inv_all on the same edge as pmem_resp -> second fill of the same address.
5. Drop mem_read two cycles into FILL -> fill completes, no mem_resp; re-request 0x0006 -> hit, mem_resp in N+1 with 0x4004.
6. Assert rst_n=0 mid-FILL -> pmem_read and mem_resp 0 without a clock edge; after release, read 0x0000 misses (valid cleared).

Source files
------------

// File: rtl/icache_fetch_responder_pkg.sv
// Shared types for the LC-3b instruction-side cache: line/tag/index/word-select
// types for the default 8-set configuration, FSM state encoding and the word mux.
package icache_fetch_responder_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 16;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

    typedef logic [127:0] lc3b_c_line;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [2:0]   lc3b_c_wordsel;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FILL  = 2'd2
    } icache_state_e;

    // Word i of a line sits at bits [16i+15:16i].
    function automatic logic [15:0] line_word(input lc3b_c_line line, input lc3b_c_wordsel sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_fetch_responder_array.sv
// Per-set valid/tag/data storage: combinational read by index, synchronous
// write, and a global valid clear that takes priority over the write.
module icache_array
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 16 - 4 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    input  logic [TAG_W-1:0] wtag,
    input  lc3b_c_line       wdata,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output lc3b_c_line       rd_data
);

    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tags [NUM_SETS];
    lc3b_c_line          data [NUM_SETS];

    // A clear coinciding with a write leaves the freshly written line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx] <= wtag;
            data[idx] <= wdata;
        end
    end

    assign rd_valid = valid[idx];
    assign rd_tag   = tags[idx];
    assign rd_data  = data[idx];

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only instruction cache answering LC-3b fetches; misses are
// filled with a single 128-bit line read from physical memory.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_SETS  = 8,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          mem_address,
    input  logic                 mem_read,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    input  logic                 inv_all,
    output logic [15:0]          pmem_address,
    output logic                 pmem_read,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 16 - 4 - IW;

    icache_state_e state, state_next;
    logic [15:1]   req_addr;
    logic          addr_lsb_unused;

    logic [TW-1:0]  req_tag;
    logic [IW-1:0]  req_idx;
    lc3b_c_wordsel  req_sel;

    logic           rd_valid;
    logic [TW-1:0]  rd_tag;
    lc3b_c_line     rd_data;
    logic           hit;
    logic           fill_we;

    assign addr_lsb_unused = mem_address[0];

    assign req_tag = req_addr[15:4+IW];
    assign req_idx = req_addr[3+IW:4];
    assign req_sel = req_addr[3:1];

    // The address is captured once in IDLE; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            req_addr <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && mem_read) begin
                req_addr <= mem_address[15:1];
            end
        end
    end

    assign hit     = rd_valid && (rd_tag == req_tag);
    assign fill_we = (state == S_FILL) && pmem_resp;

    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mem_read) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                // An abandoned request (mem_read low) returns to IDLE without a fill.
                if (hit && mem_read) begin
                    mem_resp = 1'b1;
                end
                state_next = (!hit && mem_read) ? S_FILL : S_IDLE;
            end
            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    state_next = S_CHECK;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_rdata    = mem_resp ? line_word(rd_data, req_sel) : 16'h0000;
    assign pmem_address = pmem_read ? {req_tag, req_idx, 4'b0000} : 16'h0000;

    icache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IW),
        .TAG_W    (TW)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (inv_all),
        .idx      (req_idx),
        .we       (fill_we),
        .wtag     (req_tag),
        .wdata    (pmem_rdata),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized bench for icache_fetch_responder with a set/tag reference model,
// expected-data and expected-fill queues, and an independent output monitor.
module tb_icache_fetch_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         inv_all;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] fill_q[$];

    bit         mdl_valid [8];
    logic [8:0] mdl_tag   [8];

    bit inv_pending   = 1'b0;
    bit inv_with_resp = 1'b0;
    bit stray_resp    = 1'b0;
    int fill_delay    = 2;

    always #5 clk = ~clk;

    icache_fetch_responder #(.NUM_SETS(8), .LINE_BITS(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .inv_all      (inv_all),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    // Memory image: word at byte address a = line base XOR 0x1001*(word+1).
    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] k;
        k = {13'd0, a[3:1]} + 16'd1;
        return {a[15:4], 4'b0000} ^ (16'h1001 * k);
    endfunction

    function automatic logic [127:0] line_of(input logic [15:0] la);
        logic [127:0] l;
        logic [15:0]  wa;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            wa = {la[15:4], i[2:0], 1'b0};
            l[i*16 +: 16] = word_at(wa);
        end
        return l;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_miss(input logic [15:0] a);
        return !(mdl_valid[a[6:4]] && mdl_tag[a[6:4]] == a[15:7]);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 8; s++) mdl_valid[s] = 1'b0;
    endfunction

    // Records the fills a request should cause and installs the line in the model.
    function automatic bit model_predict(input logic [15:0] a);
        bit miss;
        miss = model_miss(a);
        if (miss) begin
            fill_q.push_back({a[15:4], 4'b0000});
            if (inv_with_resp) begin
                fill_q.push_back({a[15:4], 4'b0000});
                model_clear();
            end
        end
        mdl_valid[a[6:4]] = 1'b1;
        mdl_tag[a[6:4]]   = a[15:7];
        return miss;
    endfunction

    // One cycle of input driving at the falling edge, including the pmem responder.
    task automatic tick();
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        inv_all    = inv_pending;
        inv_pending = 1'b0;
        if (stray_resp) begin
            pmem_resp  = 1'b1;
            stray_resp = 1'b0;
        end else if (pmem_read) begin
            if (fill_delay <= 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line_of(pmem_address);
                fill_delay = $urandom_range(0, 3);
                if (inv_with_resp) begin
                    inv_all       = 1'b1;
                    inv_with_resp = 1'b0;
                end
            end else begin
                fill_delay--;
            end
        end
    endtask

    task automatic fetch(input logic [15:0] a);
        bit miss;
        bit done;
        int n;
        tick();
        mem_address = a;
        mem_read    = 1'b1;
        miss = model_predict(a);
        exp_q.push_back(word_at(a));
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_resp) begin
                done = 1'b1;
            end else begin
                tick();
                mem_address = 16'($urandom);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no mem_resp for %h within %0d cycles", a, n);
        end else if (!miss) begin
            check16("hit_latency", 16'(n), 16'd1);
        end else begin
            check_bit("miss_resp_after_pmem_resp", pmem_resp, 1'b1);
        end
        tick();
        mem_read = 1'b0;
    endtask

    task automatic wait_pmem_read(input logic level, input string name);
        int n;
        n = 0;
        while (pmem_read !== level && n < 60) begin
            tick();
            @(posedge clk);
            #1;
            n++;
        end
        check_bit(name, pmem_read, level);
    endtask

    // Monitor: pops expected data on every response, expected address on every fill start.
    initial begin : monitor
        logic        prev_resp;
        logic        prev_pread;
        logic [15:0] prev_paddr;
        prev_resp  = 1'b0;
        prev_pread = 1'b0;
        prev_paddr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (mem_resp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got rdata %h expected no response at %0t", mem_rdata, $time);
                    end else begin
                        check16("rdata", mem_rdata, exp_q.pop_front());
                    end
                    check_bit("resp_not_consecutive", prev_resp, 1'b0);
                end else if (mem_rdata !== 16'h0000) begin
                    check16("rdata_idle_zero", mem_rdata, 16'h0000);
                end
                if (pmem_read && !prev_pread) begin
                    if (fill_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fill: got pmem_address %h expected no fill at %0t", pmem_address, $time);
                    end else begin
                        check16("fill_addr", pmem_address, fill_q.pop_front());
                    end
                end else if (pmem_read && prev_pread) begin
                    check16("fill_addr_stable", pmem_address, prev_paddr);
                end
                prev_resp  = mem_resp;
                prev_pread = pmem_read;
                prev_paddr = pmem_address;
            end else begin
                prev_resp  = 1'b0;
                prev_pread = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [15:0] a;
        mem_address = '0;
        mem_read    = 1'b0;
        inv_all     = 1'b0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        model_clear();
        for (int s = 0; s < 8; s++) mdl_tag[s] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check_bit("reset_mem_resp", mem_resp, 1'b0);
        check16("reset_mem_rdata", mem_rdata, 16'h0000);
        check_bit("reset_pmem_read", pmem_read, 1'b0);
        check16("reset_pmem_address", pmem_address, 16'h0000);
        rst_n = 1'b1;

        // Cold miss, then hit in the same line, then conflict evictions
        fill_delay = 3;
        fetch(16'h0006);
        fetch(16'h000A);
        fetch(16'h0080);
        fetch(16'h0000);

        // Invalidate while idle, then invalidate coinciding with the fill write
        inv_pending = 1'b1;
        model_clear();
        tick();
        fetch(16'h000A);
        inv_with_resp = 1'b1;
        fetch(16'h0086);

        // Abandon a request during the fill; the fill still completes silently
        tick();
        mem_address = 16'h0006;
        mem_read    = 1'b1;
        void'(model_predict(16'h0006));
        fill_delay = 5;
        wait_pmem_read(1'b1, "abandon_fill_start");
        tick();
        tick();
        mem_read = 1'b0;
        wait_pmem_read(1'b0, "abandon_fill_done");
        repeat (3) tick();
        fetch(16'h0006);

        // Reset asserted in the middle of a fill
        tick();
        mem_address = 16'h0100;
        mem_read    = 1'b1;
        void'(model_predict(16'h0100));
        fill_delay = 20;
        wait_pmem_read(1'b1, "rst_fill_start");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("rst_async_pmem_read", pmem_read, 1'b0);
        check_bit("rst_async_mem_resp", mem_resp, 1'b0);
        check16("rst_async_pmem_address", pmem_address, 16'h0000);
        mem_read = 1'b0;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        stray_resp = 1'b1;
        tick();
        @(posedge clk);
        #1;
        check_bit("stray_pmem_resp_ignored", pmem_read, 1'b0);
        fill_delay = 1;
        fetch(16'h0000);

        // Random traffic over four tags per set, with occasional invalidates
        for (int it = 0; it < 200; it++) begin
            a = 16'($urandom_range(0, 511)) & 16'h01FE;
            if ($urandom_range(0, 15) == 0) begin
                inv_pending = 1'b1;
                model_clear();
                tick();
            end
            if ($urandom_range(0, 9) == 0 && model_miss(a)) begin
                inv_with_resp = 1'b1;
            end
            fetch(a);
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (4) tick();
        check16("exp_q_drained", 16'(exp_q.size()), 16'd0);
        check16("fill_q_drained", 16'(fill_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
